instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stall  input  1  downstream (IF_ID) cannot accept a new instruction; outputs hold.
REQ-005 SHALL have ports jump / jump_target  input  1 / 32  unconditional redirect request and its target.
REQ-006 SHALL have ports branch_taken / branch_target  input  1 / 32  taken-branch redirect request and its target.
REQ-007 SHALL have ports imem_req / imem_addr  output  1 / 32  instruction-memory request and word address.
REQ-008 SHALL have ports imem_ack / imem_rdata  input  1 / 32  one-cycle completion pulse and its read data.
REQ-009 SHALL have ports instruccionOut / PC4Out / valid_out  output  32 / 32 / 1  registered fetched word, its PC+4, and word-valid flag feeding IF_ID.

Function
REQ-010 SHALL hold imem_req and imem_addr stable from assertion until the cycle imem_ack is sampled high; a new request may begin the following cycle.
REQ-011 SHALL force imem_addr[1:0] and all stored targets' bits [1:0] to 0.
REQ-012 SHALL select redirect with priority jump over branch_taken; redirect overrides stall.
REQ-013 SHALL implement states FETCH (req=1, addr=PC), HOLD (req=0, word buffered), and DISCARD (req=1, addr=PC, data squashed).
REQ-014 In FETCH, on ack with no redirect and stall=0: load outputs with imem_rdata and PC+4, set valid_out=1, set PC=PC+4, and stay in FETCH.
REQ-015 In FETCH, on ack with no redirect and stall=1: buffer imem_rdata and PC+4, set PC=PC+4, leave outputs unchanged, and go to HOLD.
REQ-016 In FETCH without ack: if stall=0, load instruccionOut=0 (NOP) and valid_out=0 (bubble); if stall=1, hold outputs.
REQ-017 In FETCH, on redirect coincident with ack: drop data, set PC=target, stay in FETCH; on redirect without ack: store target and go to DISCARD.
REQ-018 In HOLD, when stall falls: move the buffer to outputs with valid_out=1 and go to FETCH; on redirect: drop the buffer, set PC=target, go to FETCH.
REQ-019 In DISCARD, on ack: drop data, set PC=stored target, go to FETCH; a further redirect before ack overwrites the stored target.
REQ-020 On any redirect, SHALL load outputs with instruccionOut=0, PC4Out=0, valid_out=0 on the same edge (flush).
REQ-021 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 SHALL ignore imem_ack while in HOLD.

Reset
REQ-023 While rst_n=0: PC=RESET_PC, state=FETCH, instruccionOut=0, PC4Out=0, valid_out=0, buffers and stored target=0, imem_req=0.
REQ-024 SHALL assert imem_req with addr=RESET_PC in the first cycle after rst_n rises; an outstanding request at reset is abandoned.

Structure
REQ-025 SHALL place the state encoding, NOP word (32'h0) and PC increment (4) in shared package mips_pkg.
REQ-026 SHALL be a single module with no sub-modules; the PC+4 adder is inline.

Verification
REQ-027 Reset release with RESET_PC=0x100, ack every cycle, rdata=0xAAAA0000+addr SHALL produce imem_addr 0x100, 0x104, ... and outputs 0xAAAA0100/PC4Out 0x104, then 0xAAAA0104/0x108, with valid_out=1.
REQ-028 Stall=1 for 3 cycles coincident with ack at 0x108 SHALL freeze outputs at 0x104 data, drop imem_req, then present 0x108 data/PC4Out 0x10C one cycle after stall falls.
REQ-029 branch_taken=1, target 0x200, while a 0x10C request awaits ack for 2 cycles SHALL flush outputs (valid_out=0), keep addr 0x10C until ack, drop that data, then request 0x200.
REQ-030 jump=1 (0x300) and branch_taken=1 (0x200) in the same cycle SHALL give next fetch address 0x300; a target of 0x303 SHALL fetch 0x300.
REQ-031 PC=0xFFFFFFFC fetched with ack SHALL give PC4Out=0 and a next request at 0x0.
REQ-032 rst_n low during DISCARD SHALL immediately zero all outputs and drop imem_req, then restart at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: FSM encoding, the NOP word and the PC step.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  // Instruction addresses are word aligned; low two bits are always cleared.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives a req/ack instruction memory, handles stall,
// jump/branch redirects, and presents registered words to IF_ID.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruccionOut,
  output logic [31:0] PC4Out,
  output logic        valid_out,
  output if_state_e   dbg_state
);

  // Memory handshake: imem_req/imem_addr stay stable from assertion until the
  // cycle imem_ack is sampled high; ack is a one-cycle completion pulse and a
  // new request may start on the following cycle. Ack is ignored without req.
  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] tgt_q, tgt_d;
  logic        req_en_q;

  logic        redirect;
  logic [31:0] redir_tgt;
  logic        ack;
  logic [31:0] pc_plus4;

  assign redirect  = jump | branch_taken;
  assign redir_tgt = word_align(jump ? jump_target : branch_target);
  assign ack       = imem_ack & imem_req;
  assign pc_plus4  = pc_q + PC_INC;

  assign imem_req       = req_en_q & (state_q != ST_HOLD);
  assign imem_addr      = pc_q;
  assign instruccionOut = instr_q;
  assign PC4Out         = pc4_q;
  assign valid_out      = valid_q;
  assign dbg_state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= word_align(RESET_PC);
      instr_q     <= NOP_WORD;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      tgt_q       <= '0;
      req_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      tgt_q       <= tgt_d;
      req_en_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    tgt_d       = tgt_q;

    // A redirect flushes IF_ID on the same edge, even while stalled.
    if (redirect) begin
      instr_d = NOP_WORD;
      pc4_d   = '0;
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          if (ack || !imem_req) begin
            pc_d = redir_tgt;
          end else begin
            tgt_d   = redir_tgt;
            state_d = ST_DISCARD;
          end
        end else if (ack) begin
          pc_d = pc_plus4;
          if (!stall) begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = pc_plus4;
            state_d     = ST_HOLD;
          end
        end else if (!stall) begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redir_tgt;
          state_d = ST_FETCH;
        end else if (!stall) begin
          instr_d = buf_instr_q;
          pc4_d   = buf_pc4_q;
          valid_d = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        // The outstanding word is stale; only the newest target survives.
        if (redirect) begin
          if (ack) begin
            pc_d    = redir_tgt;
            state_d = ST_FETCH;
          end else begin
            tgt_d = redir_tgt;
          end
        end else if (ack) begin
          pc_d    = tgt_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: scenario tasks plus a scoreboard
// that matches every word delivered to IF_ID against the expected queue.
module tb_instruction_fetch;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruccionOut;
  logic [31:0] PC4Out;
  logic        valid_out;
  if_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic        stall_seen = 1'b0;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .jump           (jump),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instruccionOut (instruccionOut),
    .PC4Out         (PC4Out),
    .valid_out      (valid_out),
    .dbg_state      (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) stall_seen = stall;

  // scoreboard: a new word reaches IF_ID on every edge with stall low and valid high
  always @(negedge clk) begin
    logic [63:0] exp;
    if (rst_n && !stall_seen && valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected word %h pc4 %h", instruccionOut, PC4Out);
      end else begin
        exp = exp_q.pop_front();
        if ({instruccionOut, PC4Out} !== exp) begin
          errors++;
          $display("FAIL scoreboard: got %h/%h exp %h/%h",
                   instruccionOut, PC4Out, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  // driver: one cycle of memory response; inputs change on the falling edge
  task automatic tick(input bit give_ack, input bit push);
    imem_ack   = give_ack;
    imem_rdata = 32'hAAAA_0000 + imem_addr;
    if (give_ack && push) exp_q.push_back({imem_rdata, imem_addr + 32'd4});
    @(negedge clk);
    imem_ack     = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    checks++;
    if ({instruccionOut, PC4Out} !== 64'h0 || valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got %h/%h/%b exp 0/0/0", instruccionOut, PC4Out, valid_out);
    end
    checks++;
    if (dbg_state !== ST_FETCH) begin errors++; $display("FAIL reset_state: got %0d exp FETCH", dbg_state); end
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL reset_first_req: got %b/%h exp 1/00000100", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_addr !== 32'h100 + 32'(4 * i)) begin
        errors++; $display("FAIL stream_addr: got %h exp %h", imem_addr, 32'h100 + 32'(4 * i));
      end
      tick(1'b1, 1'b1);
      checks++;
      if (instruccionOut !== 32'hAAAA_0100 + 32'(4 * i) || PC4Out !== 32'h104 + 32'(4 * i) || valid_out !== 1'b1) begin
        errors++; $display("FAIL stream_out: got %h/%h/%b exp %h/%h/1", instruccionOut, PC4Out, valid_out,
                           32'hAAAA_0100 + 32'(4 * i), 32'h104 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    checks++;
    if (imem_addr !== 32'h108) begin errors++; $display("FAIL stall_addr: got %h exp 00000108", imem_addr); end
    tick(1'b1, 1'b1);
    checks++;
    if (instruccionOut !== 32'hAAAA_0104 || PC4Out !== 32'h108 || imem_req !== 1'b0 || dbg_state !== ST_HOLD) begin
      errors++; $display("FAIL stall_hold: got %h/%h req %b st %0d exp AAAA0104/00000108 req 0 HOLD",
                         instruccionOut, PC4Out, imem_req, dbg_state);
    end
    // stray acks while holding must be ignored
    repeat (2) begin
      tick(1'b1, 1'b0);
      checks++;
      if (instruccionOut !== 32'hAAAA_0104 || imem_req !== 1'b0 || dbg_state !== ST_HOLD) begin
        errors++; $display("FAIL stall_frozen: got %h req %b st %0d exp AAAA0104 req 0 HOLD",
                           instruccionOut, imem_req, dbg_state);
      end
    end
    stall = 1'b0;
    tick(1'b0, 1'b0);
    checks++;
    if (instruccionOut !== 32'hAAAA_0108 || PC4Out !== 32'h10C || valid_out !== 1'b1) begin
      errors++; $display("FAIL stall_release: got %h/%h/%b exp AAAA0108/0000010c/1", instruccionOut, PC4Out, valid_out);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin
      errors++; $display("FAIL stall_next_req: got %b/%h exp 1/0000010c", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_flush();
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    tick(1'b0, 1'b0);
    checks++;
    if ({instruccionOut, PC4Out} !== 64'h0 || valid_out !== 1'b0) begin
      errors++; $display("FAIL branch_flush: got %h/%h/%b exp 0/0/0", instruccionOut, PC4Out, valid_out);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10C || dbg_state !== ST_DISCARD) begin
      errors++; $display("FAIL branch_discard: got %b/%h st %0d exp 1/0000010c DISCARD", imem_req, imem_addr, dbg_state);
    end
    tick(1'b0, 1'b0);
    checks++;
    if (imem_addr !== 32'h10C) begin errors++; $display("FAIL branch_addr_stable: got %h exp 0000010c", imem_addr); end
    tick(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 32'h200 || valid_out !== 1'b0) begin
      errors++; $display("FAIL branch_target: got %h/%b exp 00000200/0", imem_addr, valid_out);
    end
    tick(1'b1, 1'b1);
    checks++;
    if (instruccionOut !== 32'hAAAA_0200 || PC4Out !== 32'h204) begin
      errors++; $display("FAIL branch_first_word: got %h/%h exp AAAA0200/00000204", instruccionOut, PC4Out);
    end
  endtask

  task automatic test_priority();
    jump          = 1'b1;
    jump_target   = 32'h300;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    tick(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 32'h300 || valid_out !== 1'b0) begin
      errors++; $display("FAIL prio_jump_wins: got %h/%b exp 00000300/0", imem_addr, valid_out);
    end
    tick(1'b1, 1'b1);
    jump        = 1'b1;
    jump_target = 32'h503;
    tick(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 32'h500) begin errors++; $display("FAIL prio_align: got %h exp 00000500", imem_addr); end
    branch_taken  = 1'b1;
    branch_target = 32'h600;
    tick(1'b0, 1'b0);
    checks++;
    if (imem_addr !== 32'h500 || dbg_state !== ST_DISCARD) begin
      errors++; $display("FAIL prio_discard: got %h st %0d exp 00000500 DISCARD", imem_addr, dbg_state);
    end
    jump        = 1'b1;
    jump_target = 32'h700;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 32'h700) begin errors++; $display("FAIL prio_overwrite: got %h exp 00000700", imem_addr); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1;
    tick(1'b1, 1'b0);
    checks++;
    if (dbg_state !== ST_HOLD) begin errors++; $display("FAIL sr_hold: got %0d exp HOLD", dbg_state); end
    jump        = 1'b1;
    jump_target = 32'h800;
    tick(1'b0, 1'b0);
    checks++;
    if (dbg_state !== ST_FETCH || imem_req !== 1'b1 || imem_addr !== 32'h800 || valid_out !== 1'b0) begin
      errors++; $display("FAIL sr_redirect: got st %0d req %b addr %h v %b exp FETCH 1 00000800 0",
                         dbg_state, imem_req, imem_addr, valid_out);
    end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    tick(1'b1, 1'b0);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); end
    tick(1'b1, 1'b1);
    checks++;
    if (PC4Out !== 32'h0 || instruccionOut !== 32'hAAA9_FFFC || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_pc4: got %h/%h addr %h exp aaa9fffc/00000000 addr 0", instruccionOut, PC4Out, imem_addr);
    end
    tick(1'b0, 1'b0);
    checks++;
    if (valid_out !== 1'b0 || instruccionOut !== NOP_WORD) begin
      errors++; $display("FAIL bubble: got %h/%b exp 00000000/0", instruccionOut, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_addr;
    bit give;
    exp_addr = 32'h0;
    for (int i = 0; i < 24; i++) begin
      give = 1'($urandom_range(0, 1));
      checks++;
      if (imem_addr !== exp_addr) begin errors++; $display("FAIL b2b_addr: got %h exp %h", imem_addr, exp_addr); end
      tick(give, 1'b1);
      if (give) exp_addr = exp_addr + 32'd4;
      checks++;
      if (valid_out !== give) begin errors++; $display("FAIL b2b_valid: got %b exp %b", valid_out, give); end
    end
  endtask

  task automatic test_reset_discard();
    branch_taken  = 1'b1;
    branch_target = 32'h900;
    tick(1'b0, 1'b0);
    checks++;
    if (dbg_state !== ST_DISCARD) begin errors++; $display("FAIL rd_enter: got %0d exp DISCARD", dbg_state); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || valid_out !== 1'b0 || {instruccionOut, PC4Out} !== 64'h0 || dbg_state !== ST_FETCH) begin
      errors++; $display("FAIL rd_async: got req %b v %b %h/%h st %0d exp 0 0 0/0 FETCH",
                         imem_req, valid_out, instruccionOut, PC4Out, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL rd_restart: got %b/%h exp 1/00000100", imem_req, imem_addr);
    end
    tick(1'b1, 1'b1);
    checks++;
    if (instruccionOut !== 32'hAAAA_0100 || PC4Out !== 32'h104) begin
      errors++; $display("FAIL rd_first_word: got %h/%h exp AAAA0100/00000104", instruccionOut, PC4Out);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    stall         = 1'b0;
    jump          = 1'b0;
    jump_target   = '0;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_flush();
    test_priority();
    test_stall_redirect();
    test_wrap();
    test_back_to_back();
    test_reset_discard();
    tick(1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
